adder_arbiter: RTL and testbench

Shares one fully pipelined W-bit adder (the 128-bit, 8×16-bit staged adder, fixed latency LAT) between two requesters. Round-robin grants at most one add per cycle, drives the adder operand inputs, and tracks each issued op's owner through a LAT-deep tag pipeline. Returns each result to its originator with a one-cycle valid pulse. Sits between the two client blocks and the shared adder instance.

---
 rtl/adder_arbiter_if.sv | 46 ++++
 rtl/adder_arbiter.sv | 61 ++++++
 tb/tb_adder_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Bundle between the two requesters, the shared pipelined adder and the arbiter.
// slave = arbiter side, master = clients + adder side.
interface adder_arbiter_if #(
    parameter int W   = 128,
    parameter int LAT = 10
);
    localparam int IW = $clog2(LAT + 1);

    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;

    logic [W-1:0] add_a, add_b, add_s;
    logic         add_cin, add_cout;

    logic         rsp0_valid, rsp0_cout;
    logic [W-1:0] rsp0_s;
    logic         rsp1_valid, rsp1_cout;
    logic [W-1:0] rsp1_s;

    logic [IW-1:0] inflight;
    logic          busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output add_a, add_b, add_cin,
        input  add_s, add_cout,
        output rsp0_valid, rsp0_s, rsp0_cout,
        output rsp1_valid, rsp1_s, rsp1_cout,
        output inflight, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  add_a, add_b, add_cin,
        output add_s, add_cout,
        input  rsp0_valid, rsp0_s, rsp0_cout,
        input  rsp1_valid, rsp1_s, rsp1_cout,
        input  inflight, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined adder between two requesters;
// a LAT-deep owner tag pipeline routes each sum back to whoever issued it.
module adder_arbiter #(
    parameter int W   = 128,
    parameter int LAT = 10
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);
    localparam int IW = $clog2(LAT + 1);

    logic           r_prio;
    logic [LAT-1:0] r_tag_v;
    logic [LAT-1:0] r_tag_own;
    logic [IW-1:0]  r_inflight;

    logic w_gnt0, w_gnt1, w_issue, w_retire;

    // r_prio names the requester that wins when both are valid
    assign w_gnt0   = bus.req0_valid && (!bus.req1_valid || !r_prio);
    assign w_gnt1   = bus.req1_valid && (!bus.req0_valid ||  r_prio);
    assign w_issue  = w_gnt0 || w_gnt1;
    assign w_retire = r_tag_v[LAT-1];

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;

    assign bus.add_a   = w_gnt0 ? bus.req0_a   : (w_gnt1 ? bus.req1_a   : '0);
    assign bus.add_b   = w_gnt0 ? bus.req0_b   : (w_gnt1 ? bus.req1_b   : '0);
    assign bus.add_cin = w_gnt0 ? bus.req0_cin : (w_gnt1 ? bus.req1_cin : 1'b0);

    assign bus.rsp0_valid = r_tag_v[LAT-1] && !r_tag_own[LAT-1];
    assign bus.rsp1_valid = r_tag_v[LAT-1] &&  r_tag_own[LAT-1];
    assign bus.rsp0_s     = bus.add_s;
    assign bus.rsp0_cout  = bus.add_cout;
    assign bus.rsp1_s     = bus.add_s;
    assign bus.rsp1_cout  = bus.add_cout;

    assign bus.inflight = r_inflight;
    assign bus.busy     = (r_inflight != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio     <= 1'b0;
            r_tag_v    <= '0;
            r_tag_own  <= '0;
            r_inflight <= '0;
        end else begin
            if (w_issue)
                r_prio <= w_gnt0;
            r_tag_v   <= {r_tag_v[LAT-2:0], w_issue};
            r_tag_own <= {r_tag_own[LAT-2:0], w_gnt1};
            case ({w_issue, w_retire})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a pipelined adder model and a queue-based
// scoreboard that predicts grants, operand muxing, tagged responses and inflight.
module tb_adder_arbiter;
    localparam int W   = 128;
    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adder_arbiter_if #(.W(W), .LAT(LAT)) bus ();
    adder_arbiter #(.W(W), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int rsp_cnt  = 0;

    task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    // Shared adder: sum of presented operands appears LAT edges later, never reset
    logic [W:0] apipe [LAT];
    initial for (int k = 0; k < LAT; k++) apipe[k] = '0;
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) apipe[k] <= apipe[k-1];
        apipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};
    end
    assign bus.add_s    = apipe[LAT-1][W-1:0];
    assign bus.add_cout = apipe[LAT-1][W];

    // Scoreboard: each issued op becomes an expected response due LAT cycles later
    typedef struct {
        logic       owner;
        logic [W:0] res;
        int         due;
    } ent_t;
    ent_t q[$];
    bit   m_prio = 1'b0;
    int   cyc    = 0;

    function automatic logic mg0();
        return bus.req0_valid && (!bus.req1_valid || !m_prio);
    endfunction
    function automatic logic mg1();
        return bus.req1_valid && (!bus.req0_valid || m_prio);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_prio = 1'b0;
        end else begin
            ent_t e;
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (mg0() || mg1()) begin
                e.owner = mg1();
                e.res   = mg1() ? ({1'b0, bus.req1_a} + {1'b0, bus.req1_b} + {{W{1'b0}}, bus.req1_cin})
                                : ({1'b0, bus.req0_a} + {1'b0, bus.req0_b} + {{W{1'b0}}, bus.req0_cin});
                e.due   = cyc + LAT;
                q.push_back(e);
                m_prio  = !e.owner;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic g0, g1, ev0, ev1;
        logic [W-1:0] ea, eb;
        logic ec;
        g0  = mg0();
        g1  = mg1();
        ea  = g0 ? bus.req0_a   : (g1 ? bus.req1_a   : '0);
        eb  = g0 ? bus.req0_b   : (g1 ? bus.req1_b   : '0);
        ec  = g0 ? bus.req0_cin : (g1 ? bus.req1_cin : 1'b0);
        ev0 = !rst && q.size() > 0 && q[0].due == cyc && !q[0].owner;
        ev1 = !rst && q.size() > 0 && q[0].due == cyc &&  q[0].owner;
        chk("req0_ready", {{W{1'b0}}, bus.req0_ready}, {{W{1'b0}}, g0});
        chk("req1_ready", {{W{1'b0}}, bus.req1_ready}, {{W{1'b0}}, g1});
        chk("add_a", {1'b0, bus.add_a}, {1'b0, ea});
        chk("add_b", {1'b0, bus.add_b}, {1'b0, eb});
        chk("add_cin", {{W{1'b0}}, bus.add_cin}, {{W{1'b0}}, ec});
        chk("rsp0_valid", {{W{1'b0}}, bus.rsp0_valid}, {{W{1'b0}}, ev0});
        chk("rsp1_valid", {{W{1'b0}}, bus.rsp1_valid}, {{W{1'b0}}, ev1});
        if (ev0) chk("rsp0_data", {bus.rsp0_cout, bus.rsp0_s}, q[0].res);
        if (ev1) chk("rsp1_data", {bus.rsp1_cout, bus.rsp1_s}, q[0].res);
        chk("inflight", {{(W-3){1'b0}}, bus.inflight}, (W+1)'(q.size()));
        chk("busy", {{W{1'b0}}, bus.busy}, {{W{1'b0}}, q.size() != 0});
        if (bus.rsp0_valid || bus.rsp1_valid) rsp_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 2) step();
    endtask

    int exp_gnt [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_inflight", {{(W-3){1'b0}}, bus.inflight}, '0);
        chk("rst_busy", {{W{1'b0}}, bus.busy}, '0);
        chk("rst_rsp0", {{W{1'b0}}, bus.rsp0_valid}, '0);
        chk("rst_rsp1", {{W{1'b0}}, bus.rsp1_valid}, '0);
        step();
        rst = 1'b0;

        // single op 5+7+1 on requester 0
        bus.req0_valid = 1; bus.req0_a = 128'd5; bus.req0_b = 128'd7; bus.req0_cin = 1;
        step();
        bus.req0_valid = 0;
        @(negedge clk);
        chk("single_inflight1", {{(W-3){1'b0}}, bus.inflight}, 129'd1);
        repeat (LAT - 2) step();
        @(negedge clk);
        chk("single_early", {{W{1'b0}}, bus.rsp0_valid}, '0);
        step();
        @(negedge clk);
        chk("single_valid", {{W{1'b0}}, bus.rsp0_valid}, 129'd1);
        chk("single_sum", {1'b0, bus.rsp0_s}, 129'd13);
        chk("single_cout", {{W{1'b0}}, bus.rsp0_cout}, '0);
        step();
        @(negedge clk);
        chk("single_after", {{W{1'b0}}, bus.rsp0_valid}, '0);
        chk("single_inflight0", {{(W-3){1'b0}}, bus.inflight}, '0);

        // contention: alternation from requester 0 after reset
        do_reset();
        begin
            int n0, n1, got;
            n0 = 0; n1 = 0;
            bus.req0_valid = 1; bus.req1_valid = 1;
            for (int i = 0; i < 6; i++) begin
                bus.req0_a = 128'(1000 + n0); bus.req0_b = 128'(n0 * 3); bus.req0_cin = n0[0];
                bus.req1_a = 128'(2000 + n1); bus.req1_b = {64'hFFFF_0000_0000_0000, 64'(n1)};
                bus.req1_cin = ~n1[0];
                @(negedge clk);
                got = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : 2);
                chk("contend_gnt", 129'(got), 129'(exp_gnt[i]));
                step();
                if (got == 0) n0++; else n1++;
            end
            bus.req0_valid = 0; bus.req1_valid = 0;
        end
        drain();

        // priority memory
        do_reset();
        bus.req1_valid = 1; bus.req1_a = 128'd9; bus.req1_b = 128'd1;
        step();
        bus.req0_valid = 1; bus.req0_a = 128'd4; bus.req0_b = 128'd4;
        @(negedge clk);
        chk("prio_after1_r0", {{W{1'b0}}, bus.req0_ready}, 129'd1);
        chk("prio_after1_r1", {{W{1'b0}}, bus.req1_ready}, '0);
        step();
        bus.req1_valid = 0;
        step();
        bus.req1_valid = 1;
        @(negedge clk);
        chk("prio_after0_r1", {{W{1'b0}}, bus.req1_ready}, 129'd1);
        chk("prio_after0_r0", {{W{1'b0}}, bus.req0_ready}, '0);
        step();
        bus.req0_valid = 0; bus.req1_valid = 0;
        drain();

        // full pipe
        bus.req0_valid = 1;
        for (int i = 0; i < 10; i++) begin
            bus.req0_a = 128'(i * 17); bus.req0_b = {128{1'b1}} - 128'(i); bus.req0_cin = 1'(i);
            step();
        end
        @(negedge clk);
        chk("full_inflight", {{(W-3){1'b0}}, bus.inflight}, 129'd10);
        chk("full_busy", {{W{1'b0}}, bus.busy}, 129'd1);
        step();
        bus.req0_valid = 0;
        @(negedge clk);
        chk("full_steady", {{(W-3){1'b0}}, bus.inflight}, 129'd10);
        drain();

        // reset mid-flight
        bus.req0_valid = 1; bus.req0_a = 128'd77; bus.req0_b = 128'd3;
        repeat (3) step();
        bus.req0_valid = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rsp0", {{W{1'b0}}, bus.rsp0_valid}, '0);
        chk("mid_rsp1", {{W{1'b0}}, bus.rsp1_valid}, '0);
        chk("mid_inflight", {{(W-3){1'b0}}, bus.inflight}, '0);
        chk("mid_busy", {{W{1'b0}}, bus.busy}, '0);
        chk("mid_add_a", {1'b0, bus.add_a}, '0);
        rsp_cnt = 0;
        step();
        rst = 1'b0;
        drain();
        chk("mid_no_rsp", 129'(rsp_cnt), '0);

        // wrap on requester 1 after reset
        bus.req1_valid = 1; bus.req1_a = {128{1'b1}}; bus.req1_b = 128'd1; bus.req1_cin = 0;
        step();
        bus.req1_valid = 0;
        repeat (LAT - 1) step();
        @(negedge clk);
        chk("wrap_valid", {{W{1'b0}}, bus.rsp1_valid}, 129'd1);
        chk("wrap_sum", {1'b0, bus.rsp1_s}, '0);
        chk("wrap_cout", {{W{1'b0}}, bus.rsp1_cout}, 129'd1);
        chk("wrap_no_rsp0", {{W{1'b0}}, bus.rsp0_valid}, '0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
